// File: rtl/gray_code_pkg.sv
// rtl/gray_code_pkg.sv - shared width constants and Gray encode/decode helper functions
package gray_code_pkg;

  localparam int GRAY_DEFAULT_BIT = 8;
  localparam int GRAY_MAX_BIT     = 64;

  // Helpers work on the widest bus; zero-extended narrower values give the same result.
  function automatic logic [GRAY_MAX_BIT-1:0] bin2gray(input logic [GRAY_MAX_BIT-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [GRAY_MAX_BIT-1:0] gray2bin(input logic [GRAY_MAX_BIT-1:0] g);
    logic [GRAY_MAX_BIT-1:0] r;
    r[GRAY_MAX_BIT-1] = g[GRAY_MAX_BIT-1];
    for (int k = GRAY_MAX_BIT-2; k >= 0; k--) begin
      r[k] = r[k+1] ^ g[k];
    end
    return r;
  endfunction

endpackage

// File: rtl/gray_prefix_xor.sv
// rtl/gray_prefix_xor.sv - combinational Gray-to-binary decoder (MSB-down prefix XOR)
module gray_prefix_xor
  import gray_code_pkg::*;
#(
  parameter int BIT = GRAY_DEFAULT_BIT
) (
  input  logic [BIT-1:0] i_gray,
  output logic [BIT-1:0] o_bin
);

  // Each bit is the XOR of itself and every more-significant Gray bit.
  for (genvar k = 0; k < BIT; k++) begin : g_bit
    assign o_bin[k] = ^(i_gray >> k);
  end

endmodule

// File: rtl/gray_code_converter.sv
// rtl/gray_code_converter.sv - registered bidirectional Gray converter; GRAY_ADJ_CHECK_EN adds o_adj_err
module gray_code_converter
  import gray_code_pkg::*;
#(
  parameter int BIT = GRAY_DEFAULT_BIT
) (
  input  logic           i_clk,
  input  logic           i_rstn,
  input  logic           i_valid,
  input  logic [BIT-1:0] i_bin,
  input  logic [BIT-1:0] i_gray,
  output logic           o_valid,
  output logic [BIT-1:0] o_gray,
  output logic [BIT-1:0] o_bin
`ifdef GRAY_ADJ_CHECK_EN
  ,
  output logic           o_adj_err
`endif
);

  logic           r_valid;
  logic [BIT-1:0] r_gray;
  logic [BIT-1:0] r_bin;
  logic [BIT-1:0] w_gray;
  logic [BIT-1:0] w_bin;

  assign w_gray = BIT'(bin2gray(GRAY_MAX_BIT'(i_bin)));

  gray_prefix_xor #(.BIT(BIT)) u_dec (
    .i_gray (i_gray),
    .o_bin  (w_bin)
  );

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_valid <= 1'b0;
      r_gray  <= '0;
      r_bin   <= '0;
    end else begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_gray <= w_gray;
        r_bin  <= w_bin;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_gray  = r_gray;
  assign o_bin   = r_bin;

`ifdef GRAY_ADJ_CHECK_EN
  logic [BIT-1:0] r_prev_gray;
  logic           r_have_hist;
  logic           r_adj_err;
  logic [BIT-1:0] w_diff;
  logic           w_multi;

  // More than one bit differs exactly when the difference is not zero or a power of two.
  assign w_diff  = i_gray ^ r_prev_gray;
  assign w_multi = |(w_diff & (w_diff - BIT'(1)));

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_prev_gray <= '0;
      r_have_hist <= 1'b0;
      r_adj_err   <= 1'b0;
    end else if (i_valid) begin
      r_prev_gray <= i_gray;
      r_have_hist <= 1'b1;
      r_adj_err   <= r_have_hist & w_multi;
    end
  end

  assign o_adj_err = r_adj_err;
`endif

endmodule

// File: tb/tb_gray_code_converter.sv
// tb/tb_gray_code_converter.sv - scoreboard bench for gray_code_converter (GRAY_ADJ_CHECK_EN aware)
module tb_gray_code_converter;
  import gray_code_pkg::*;

  localparam int BIT = 8;

  typedef struct {
    logic [BIT-1:0] g;
    logic [BIT-1:0] b;
    logic           adj;
  } exp_t;

  logic           clk;
  logic           i_rstn;
  logic           i_valid;
  logic [BIT-1:0] i_bin;
  logic [BIT-1:0] i_gray;
  logic           o_valid;
  logic [BIT-1:0] o_gray;
  logic [BIT-1:0] o_bin;
`ifdef GRAY_ADJ_CHECK_EN
  logic           o_adj_err;
`endif

  exp_t           sb[$];
  int             total = 0;
  int             bad = 0;
  logic [BIT-1:0] last_bin = '0;
  logic           m_hist = 1'b0;
  logic [BIT-1:0] m_prev = '0;
  logic           sweep_on = 1'b0;
  logic           have_prev = 1'b0;
  logic [BIT-1:0] prev_gray = '0;

  gray_code_converter #(.BIT(BIT)) dut (
    .i_clk   (clk),
    .i_rstn  (i_rstn),
    .i_valid (i_valid),
    .i_bin   (i_bin),
    .i_gray  (i_gray),
    .o_valid (o_valid),
    .o_gray  (o_gray),
    .o_bin   (o_bin)
`ifdef GRAY_ADJ_CHECK_EN
    ,
    .o_adj_err (o_adj_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Drives inputs now and records the result the DUT must show one edge later.
  task automatic apply(input logic v, input logic [BIT-1:0] b, input logic [BIT-1:0] g, input logic lb);
    exp_t e;
    i_valid = v;
    i_bin   = b;
    i_gray  = g;
    if (v && i_rstn) begin
      e.g   = BIT'(bin2gray(64'(b)));
      e.b   = lb ? last_bin : BIT'(gray2bin(64'(g)));
      e.adj = 1'b0;
`ifdef GRAY_ADJ_CHECK_EN
      e.adj  = m_hist && ($countones(g ^ m_prev) > 1);
      m_prev = g;
      m_hist = 1'b1;
`endif
      sb.push_back(e);
      last_bin = b;
    end
  endtask

  task automatic drive(input logic v, input logic [BIT-1:0] b, input logic [BIT-1:0] g, input logic lb);
    @(negedge clk);
    apply(v, b, lb ? o_gray : g, lb);
  endtask

  task automatic clear_model();
    sb.delete();
    m_hist = 1'b0;
    m_prev = '0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (i_rstn && o_valid) begin
      check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("sb_gray", 64'(o_gray), 64'(e.g));
        check("sb_bin", 64'(o_bin), 64'(e.b));
`ifdef GRAY_ADJ_CHECK_EN
        check("sb_adj", 64'(o_adj_err), 64'(e.adj));
`endif
      end
      if (sweep_on) begin
        if (have_prev) check("sweep_one_bit", 64'($countones(o_gray ^ prev_gray)), 64'd1);
        prev_gray = o_gray;
        have_prev = 1'b1;
      end
    end
  end

  initial begin
    i_rstn  = 1'b0;
    i_valid = 1'b1;
    i_bin   = 8'h55;
    i_gray  = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_gray", 64'(o_gray), 64'd0);
      check("rst_bin", 64'(o_bin), 64'd0);
      check("rst_valid", 64'(o_valid), 64'd0);
    end
    i_rstn = 1'b1;
    apply(1'b1, 8'h55, 8'hAA, 1'b0);
    drive(1'b1, 8'd5, 8'h07, 1'b0);
    check("first_valid", 64'(o_valid), 64'd1);
    check("first_gray", 64'(o_gray), 64'h7F);
    drive(1'b1, 8'hFF, 8'h80, 1'b0);
    check("pt_gray5", 64'(o_gray), 64'h07);
    check("pt_bin5", 64'(o_bin), 64'd5);
    drive(1'b1, 8'h10, 8'h00, 1'b0);
    check("pt_grayff", 64'(o_gray), 64'h80);
    check("pt_binff", 64'(o_bin), 64'hFF);
    drive(1'b0, 8'hAA, 8'h00, 1'b0);
    drive(1'b0, 8'hAA, 8'h00, 1'b0);
    check("hold_gray", 64'(o_gray), 64'h18);
    check("hold_valid", 64'(o_valid), 64'd0);

    have_prev = 1'b0;
    sweep_on  = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      drive(1'b1, BIT'(i), 8'h00, 1'b1);
    end
    drive(1'b1, 8'h21, 8'h00, 1'b0);
    #1 sweep_on = 1'b0;
    check("wrap_gray", 64'(o_gray), 64'h00);
    drive(1'b1, 8'h22, 8'h3C, 1'b0);

    @(posedge clk);
    #2 i_rstn = 1'b0;
    #1;
    check("async_gray", 64'(o_gray), 64'd0);
    check("async_bin", 64'(o_bin), 64'd0);
    check("async_valid", 64'(o_valid), 64'd0);
    clear_model();
    @(negedge clk);
    @(negedge clk);
    check("async_hold_gray", 64'(o_gray), 64'd0);
    check("async_hold_valid", 64'(o_valid), 64'd0);

    i_rstn = 1'b1;
    apply(1'b1, 8'h01, 8'h07, 1'b0);
    drive(1'b1, 8'h02, 8'h05, 1'b0);
    drive(1'b1, 8'h03, 8'h00, 1'b0);
    drive(1'b0, 8'h00, 8'h00, 1'b0);
`ifdef GRAY_ADJ_CHECK_EN
    check("adj_multi", 64'(o_adj_err), 64'd1);
`endif
    @(negedge clk);
    i_rstn = 1'b0;
    clear_model();
    @(negedge clk);
    i_rstn = 1'b1;
    apply(1'b1, 8'h04, 8'hFF, 1'b0);
    drive(1'b0, 8'h00, 8'h00, 1'b0);
`ifdef GRAY_ADJ_CHECK_EN
    check("adj_first", 64'(o_adj_err), 64'd0);
`endif
    check("last_bin", 64'(o_bin), 64'hAA);
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
